boot_sequencer: RTL

Hardware replacement for bench-driven core boot. After reset and a `start_i` request, it does three things in order:
- Preloads data memory from a boot image with word stores.
- Hands data memory ownership to the core.
- Streams instruction packets, register packets, a barrier-mask packet and a PC packet into the core's network input.

It sits between the boot image source, `data_mem`, and `core_flattened`. It owns the memory-port mux select and the core's inbound network packet.

---
 rtl/boot_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/boot_sequencer.sv
// Boot sequencer: preloads data memory from a boot image, hands the memory port to the core,
// then streams instruction, register, barrier-mask and PC packets into the core's network input.
module boot_sequencer #(
   parameter int unsigned  data_words_p   = 1024,
   parameter int unsigned  instr_words_p  = 1024,
   parameter int unsigned  reg_words_p    = 64,
   parameter logic [9:0]   net_ID_p       = 10'b1,
   parameter logic [31:0]  barrier_mask_p = 32'h2,
   parameter logic [9:0]   barrier_addr_p = 10'd24,
   parameter logic [31:0]  start_pc_p     = 32'h5,
   localparam int unsigned mem_in_w_lp    = 36,
   localparam int unsigned net_pkt_w_lp   = 59
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start_i,
   output logic [1:0]              src_sel_o,
   output logic [9:0]              src_addr_o,
   output logic                    src_rd_o,
   input  logic [39:0]             src_data_i,
   output logic [mem_in_w_lp-1:0]  mem_flat_o,
   output logic [31:0]             mem_addr_o,
   output logic                    select_o,
   output logic [net_pkt_w_lp-1:0] net_packet_flat_o,
   output logic                    busy_o,
   output logic                    done_o
);

   typedef enum logic [2:0] {
      NET_OP_NULL  = 3'd0,
      NET_OP_INSTR = 3'd1,
      NET_OP_REG   = 3'd2,
      NET_OP_PC    = 3'd3,
      NET_OP_BAR   = 3'd4
   } net_op_e;

   typedef struct packed {
      logic        valid;
      logic        yumi;
      logic        wen;
      logic        byte_not_word;
      logic [31:0] write_data;
   } mem_in_s;

   typedef struct packed {
      logic [9:0]  ID;
      net_op_e     net_op;
      logic [3:0]  reserved;
      logic [31:0] net_data;
      logic [9:0]  net_addr;
   } net_packet_s;

   typedef enum logic [3:0] {
      S_IDLE, S_DMEM_RD, S_DMEM_WR, S_DRAIN, S_HANDOFF,
      S_INS_RD, S_INS_SEND, S_REG_RD, S_REG_SEND, S_BAR, S_PC, S_DONE
   } state_e;

   localparam logic [10:0] data_cnt_lp  = 11'(data_words_p);
   localparam logic [10:0] instr_cnt_lp = 11'(instr_words_p);
   localparam logic [10:0] reg_cnt_lp   = 11'(reg_words_p);

   state_e      state_q, state_d;
   logic [10:0] d_idx_q, d_idx_d;
   logic [10:0] i_idx_q, i_idx_d;
   logic [10:0] r_idx_q, r_idx_d;
   logic        src_rd_q, src_rd_d;
   logic [1:0]  src_sel_q, src_sel_d;
   logic [9:0]  src_addr_q, src_addr_d;
   logic        select_q, select_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   mem_in_s     mem_req_c;
   logic [31:0] mem_addr_c;
   net_packet_s pkt_c;
   logic        unused_src_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         d_idx_q    <= '0;
         i_idx_q    <= '0;
         r_idx_q    <= '0;
         src_rd_q   <= 1'b0;
         src_sel_q  <= 2'd0;
         src_addr_q <= '0;
         select_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         d_idx_q    <= d_idx_d;
         i_idx_q    <= i_idx_d;
         r_idx_q    <= r_idx_d;
         src_rd_q   <= src_rd_d;
         src_sel_q  <= src_sel_d;
         src_addr_q <= src_addr_d;
         select_q   <= select_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next state, section counters, and the registered image-side / status outputs.
   always_comb begin
      state_d    = state_q;
      d_idx_d    = d_idx_q;
      i_idx_d    = i_idx_q;
      r_idx_d    = r_idx_q;
      src_rd_d   = 1'b0;
      src_sel_d  = 2'd0;
      src_addr_d = '0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      select_d   = select_q | (state_q == S_HANDOFF);

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               d_idx_d = '0;
               state_d = (data_cnt_lp == 11'd0) ? S_DRAIN : S_DMEM_RD;
            end
         end
         S_DMEM_RD: state_d = S_DMEM_WR;
         S_DMEM_WR: begin
            d_idx_d = 11'(d_idx_q + 11'd1);
            state_d = (d_idx_d == data_cnt_lp) ? S_DRAIN : S_DMEM_RD;
         end
         S_DRAIN: state_d = S_HANDOFF;
         S_HANDOFF: begin
            i_idx_d = '0;
            r_idx_d = '0;
            if (instr_cnt_lp != 11'd0)    state_d = S_INS_RD;
            else if (reg_cnt_lp != 11'd0) state_d = S_REG_RD;
            else                          state_d = S_BAR;
         end
         S_INS_RD: state_d = S_INS_SEND;
         S_INS_SEND: begin
            i_idx_d = 11'(i_idx_q + 11'd1);
            if (i_idx_d == instr_cnt_lp) begin
               r_idx_d = '0;
               state_d = (reg_cnt_lp != 11'd0) ? S_REG_RD : S_BAR;
            end else begin
               state_d = S_INS_RD;
            end
         end
         S_REG_RD: state_d = S_REG_SEND;
         S_REG_SEND: begin
            r_idx_d = 11'(r_idx_q + 11'd1);
            state_d = (r_idx_d == reg_cnt_lp) ? S_BAR : S_REG_RD;
         end
         S_BAR:   state_d = S_PC;
         S_PC:    state_d = S_DONE;
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_IDLE: busy_d = 1'b0;
         S_DONE: begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         S_DMEM_RD, S_DMEM_WR: begin
            src_rd_d   = (state_d == S_DMEM_RD);
            src_addr_d = d_idx_d[9:0];
         end
         S_INS_RD, S_INS_SEND: begin
            src_rd_d   = (state_d == S_INS_RD);
            src_sel_d  = 2'd1;
            src_addr_d = i_idx_d[9:0];
         end
         S_REG_RD, S_REG_SEND: begin
            src_rd_d   = (state_d == S_REG_RD);
            src_sel_d  = 2'd2;
            src_addr_d = r_idx_d[9:0];
         end
         default: ;
      endcase
   end

   // Image data arrives during the write/send state, so the payload is a current-state decode.
   always_comb begin
      mem_req_c      = '0;
      mem_addr_c     = '0;
      pkt_c          = '0;
      pkt_c.ID       = net_ID_p;
      pkt_c.net_op   = NET_OP_NULL;

      case (state_q)
         S_DMEM_WR: begin
            mem_req_c.valid      = 1'b1;
            mem_req_c.yumi       = 1'b1;
            mem_req_c.wen        = 1'b1;
            mem_req_c.write_data = src_data_i[31:0];
            mem_addr_c           = 32'(d_idx_q) << 2;
         end
         S_INS_SEND: begin
            pkt_c.net_op   = NET_OP_INSTR;
            pkt_c.net_data = {16'b0, src_data_i[15:0]};
            pkt_c.net_addr = i_idx_q[9:0];
         end
         S_REG_SEND: begin
            pkt_c.net_op   = NET_OP_REG;
            pkt_c.net_data = src_data_i[31:0];
            pkt_c.net_addr = {4'b0, src_data_i[37:32]};
         end
         S_BAR: begin
            pkt_c.net_op   = NET_OP_BAR;
            pkt_c.net_data = barrier_mask_p;
            pkt_c.net_addr = barrier_addr_p;
         end
         S_PC: begin
            pkt_c.net_op   = NET_OP_PC;
            pkt_c.net_data = start_pc_p;
         end
         default: ;
      endcase
   end

   assign unused_src_data   = ^src_data_i[39:38];

   assign src_sel_o         = src_sel_q;
   assign src_addr_o        = src_addr_q;
   assign src_rd_o          = src_rd_q;
   assign mem_flat_o        = mem_req_c;
   assign mem_addr_o        = mem_addr_c;
   assign select_o          = select_q;
   assign net_packet_flat_o = pkt_c;
   assign busy_o            = busy_q;
   assign done_o            = done_q;

endmodule
